prescaled_counter: RTL
======================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  WIDTH    32  counter width, 2..64
  LED_N    4   LED outputs, 1..WIDTH
  PRESC_W  8   prescaler width, 1..16
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk1      in   1        single clock; all logic on rising edge
  rst       in   1        synchronous, active-high reset
  en        in   1        count enable
  mode      in   2        00 up-wrap, 01 down-wrap, 10 one-shot up, 11 hold
  presc     in   PRESC_W  tick every presc+1 enabled cycles
  limit     in   WIDTH    one-shot terminal value
  load      in   1        synchronous load strobe
  load_val  in   WIDTH    load value
  cnt       out  WIDTH    counter value, registered
  led       out  LED_N    cnt[WIDTH-1 -: LED_N], registered with cnt
  tick      out  1        prescaler tick, registered pulse
  tc        out  1        terminal-count pulse, registered
  done      out  1        one-shot complete, level
  busy      out  1        1 while state is RUN

Function
REQ-003 States: IDLE, RUN, DONE; the state is encoded in registers; there are no latches.
REQ-004 The priority order each cycle SHALL be rst, then load, then mode/en evaluation.
REQ-005 On load, the block SHALL set cnt=load_val and pcnt=0, clear done, suppress tick and tc that cycle, and move to RUN if en=1, otherwise to IDLE.
REQ-006 IDLE->RUN when en=1 and mode!=11; RUN->IDLE when en=0 or mode=11; in IDLE, cnt and pcnt hold.
REQ-007 Prescaler, in RUN only: if pcnt>=presc, then pcnt<=0 and tick<=1; else pcnt<=pcnt+1 and tick<=0; tick SHALL be 0 outside RUN.
REQ-008 Counter update happens on the same edge tick is registered, so cnt and tick change together; with presc=0 and RUN, cnt changes every cycle.
REQ-009 Mode 00: cnt<=cnt+1 modulo 2^WIDTH; tc=1 in the cycle cnt shows 0 after wrapping from all-ones.
REQ-010 Mode 01: cnt<=cnt-1 modulo 2^WIDTH; tc=1 in the cycle cnt shows all-ones after wrapping from 0.
REQ-011 Mode 10: cnt<=cnt+1 with wrap permitted; when the new value equals limit, the block SHALL set tc=1 for one cycle, set done=1, and enter DONE.
REQ-012 In mode 10, cnt>limit at start SHALL count through the wrap to limit; cnt==limit at start SHALL require a full 2^WIDTH ticks.
REQ-013 In DONE: cnt, pcnt and done hold and tick=0; exit is only by load, rst, or mode!=10, which clears done and goes to RUN if en=1 and mode!=11, otherwise to IDLE.
REQ-014 tc and tick SHALL never be high for two consecutive cycles unless presc=0.
REQ-015 A mode change while in RUN SHALL take effect on the next edge without resetting pcnt or cnt.
REQ-016 A presc change to a value below the current pcnt SHALL cause a tick on the next RUN edge (per the >= rule).
REQ-017 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-018 On rst=1 at a clk1 edge: state=IDLE, cnt=0, pcnt=0, led=0, tick=0, tc=0, done=0, busy=0.
REQ-019 rst SHALL override load, en and an in-progress one-shot in the same cycle.
REQ-020 The block SHALL leave IDLE only on the first edge after rst deasserts with en=1.

Verification
REQ-021 V1: WIDTH=8, presc=0, mode=00, en=1 from reset -> cnt 0,1,2... each cycle; after 256 ticks cnt=0 with tc=1 for one cycle.
REQ-022 V2: presc=3, mode=00 -> tick every 4th cycle, cnt advances only on tick cycles; en=0 mid-run -> cnt and pcnt frozen, busy=0.
REQ-023 V3: mode=01, load_val=2, load with en=1 -> cnt 2,1,0,0xFF; tc=1 when cnt=0xFF.
REQ-024 V4: mode=10, load_val=0xFD, limit=0x02, presc=0 -> cnt FE,FF,00,01,02; done=1 and tc=1 at 02; cnt holds 02 afterwards; load clears done.
REQ-025 V5: load and rst in the same cycle -> reset values; load with en=0 -> cnt=load_val, IDLE, no tick.
REQ-026 V6: WIDTH=32, LED_N=4, load_val=0xA0000000 -> led=4'hA on the cycle after load.

Source files
------------

// File: rtl/prescaled_counter.sv
// Prescaled up/down/one-shot counter with IDLE/RUN/DONE control FSM.
// All state lives in clk1-domain registers and is cleared by a synchronous, active-high reset.
module prescaled_counter #(
    parameter int WIDTH   = 32,
    parameter int LED_N   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   limit,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   cnt,
    output logic [LED_N-1:0]   led,
    output logic               tick,
    output logic               tc,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_UP      = 2'b00;
    localparam logic [1:0] M_DOWN    = 2'b01;
    localparam logic [1:0] M_ONESHOT = 2'b10;
    localparam logic [1:0] M_HOLD    = 2'b11;

    state_t             state, state_nx;
    logic [PRESC_W-1:0] pcnt, pcnt_nx;
    logic [WIDTH-1:0]   cnt_nx, cnt_step;
    logic               tick_nx, tc_nx, done_nx;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        pcnt_nx  = pcnt;
        tick_nx  = 1'b0;
        tc_nx    = 1'b0;
        done_nx  = done;
        cnt_step = (mode == M_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);

        if (load) begin
            cnt_nx   = load_val;
            pcnt_nx  = '0;
            done_nx  = 1'b0;
            state_nx = en ? S_RUN : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && mode != M_HOLD)
                        state_nx = S_RUN;
                end
                S_RUN: begin
                    if (!en || mode == M_HOLD) begin
                        state_nx = S_IDLE;
                    end else if (pcnt >= presc) begin
                        // Counter advances on the same edge that registers tick.
                        pcnt_nx = '0;
                        tick_nx = 1'b1;
                        cnt_nx  = cnt_step;
                        case (mode)
                            M_UP:    tc_nx = (cnt_step == '0);
                            M_DOWN:  tc_nx = &cnt_step;
                            M_ONESHOT: begin
                                if (cnt_step == limit) begin
                                    tc_nx    = 1'b1;
                                    done_nx  = 1'b1;
                                    state_nx = S_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        pcnt_nx = pcnt + PRESC_W'(1);
                    end
                end
                S_DONE: begin
                    if (mode != M_ONESHOT) begin
                        done_nx  = 1'b0;
                        state_nx = (en && mode != M_HOLD) ? S_RUN : S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            pcnt  <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pcnt  <= pcnt_nx;
            tick  <= tick_nx;
            tc    <= tc_nx;
            done  <= done_nx;
        end
    end

    assign led  = cnt[WIDTH-1 -: LED_N];
    assign busy = (state == S_RUN);

endmodule
